// File: rtl/dmem_access_ctrl_pkg.sv
// Shared memory-stage definitions: access size codes, controller state, func3 codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_mem_pkg;

    // Access size as carried in func3[1:0]
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Load/store func3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Natural alignment check; size 11 has no legal encoding.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline <-> data-memory controller request/response bundle.
// Latency: n/a (wires only).
// Backpressure: stall from slave; master holds request fields stable while stall=1.
// master = MEM stage (drives flush and req_*), slave = controller (drives stall, rdata*, misalign).
interface dmem_access_ctrl_if;
    logic        flush;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;

    modport master (
        output flush, req_read, req_write, req_size, req_addr, req_wdata, req_wmask,
        input  stall, rdata, rdata_valid, misalign
    );

    modport slave (
        input  flush, req_read, req_write, req_size, req_addr, req_wdata, req_wmask,
        output stall, rdata, rdata_valid, misalign
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane shifter: LOAD=0 moves data/mask up by off (store), LOAD=1 moves down (load realign).
// Latency: combinational.
// Backpressure: none.
// Ports: off (byte offset), data_in/mask_in -> data_out/mask_out.
module dmem_lane_align #(
    parameter bit LOAD = 1'b0
) (
    input  logic [1:0]  off,
    input  logic [31:0] data_in,
    input  logic [3:0]  mask_in,
    output logic [31:0] data_out,
    output logic [3:0]  mask_out
);
    always_comb begin
        data_out = '0;
        mask_out = '0;
        if (LOAD) begin
            data_out = data_in >> {off, 3'b000};
            mask_out = mask_in >> off;
        end else begin
            data_out = data_in << {off, 3'b000};
            mask_out = mask_in << off;
        end
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: lane-aligns stores, realigns loads, flags misaligned access.
// Latency: store 1 cycle, no stall; load stalls READ_LATENCY+1 cycles, rdata_valid the cycle after.
// Backpressure: stall holds IF..MEM during a load; flush drops an in-flight load.
// Ports: clk, rstn, pipe (slave request/response bundle), bram_* synchronous BRAM port.
module dmem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    dmem_access_ctrl_if.slave pipe,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout
);
    dmem_state_t state;
    logic [1:0]  cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;

    logic [1:0]  off;
    logic        bad;
    logic        idle_live;
    logic        do_store;
    logic        do_load;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [1:0]  ld_off;
    logic [31:0] ld_data;
    logic [3:0]  ld_mask_unused;
    logic        addr_hi_unused;

    assign off            = pipe.req_addr[1:0];
    assign bad            = size_misaligned(pipe.req_size, off);
    assign addr_hi_unused = ^pipe.req_addr[31:ADDR_W+2];

    // rstn is folded in so that every combinational output is zero during reset,
    // even while the pipeline still holds a request on the inputs.
    assign idle_live = rstn && (state == IDLE) && !pipe.flush;
    // A simultaneous read+write is executed as a store.
    assign do_store  = idle_live && pipe.req_write && !bad;
    assign do_load   = idle_live && pipe.req_read && !pipe.req_write && !bad;

    dmem_lane_align #(.LOAD(1'b0)) u_store_align (
        .off      (off),
        .data_in  (pipe.req_wdata),
        .mask_in  (pipe.req_wmask),
        .data_out (st_data),
        .mask_out (st_mask)
    );

    // Word loads are always aligned, so their offset is forced to zero.
    assign ld_off = (size_q == SIZE_W) ? 2'b00 : off_q;

    dmem_lane_align #(.LOAD(1'b1)) u_load_align (
        .off      (ld_off),
        .data_in  (rdata_q),
        .mask_in  (4'hF),
        .data_out (ld_data),
        .mask_out (ld_mask_unused)
    );

    assign bram_en   = do_store || do_load;
    assign bram_we   = do_store ? st_mask : 4'b0000;
    assign bram_din  = rstn ? st_data : '0;
    assign bram_addr = rstn ? pipe.req_addr[ADDR_W+1:2] : '0;

    assign pipe.misalign    = idle_live && (pipe.req_read || pipe.req_write) && bad;
    // Issue cycle plus every WAIT cycle; derived from state and request only, never bram_dout.
    assign pipe.stall       = do_load || ((state == WAIT) && !pipe.flush);
    assign pipe.rdata_valid = (state == DONE) && !pipe.flush;
    assign pipe.rdata       = ld_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            off_q   <= 2'd0;
            size_q  <= SIZE_B;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_load) begin
                        off_q  <= off;
                        size_q <= pipe.req_size;
                        cnt    <= 2'(READ_LATENCY - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (pipe.flush) begin
                        state <= IDLE;
                    end else if (cnt == 2'd0) begin
                        rdata_q <= bram_dout;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table, directed multi-cycle sequences, random ops vs byte-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_access_ctrl;
    import cpu_mem_pkg::*;

    localparam int ADDR_W = 12;
    localparam int RL     = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dmem_access_ctrl_if pipe ();

    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pipe      (pipe),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    // BRAM with RL-cycle read pipeline and a bench preload port
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       rd_pipe [0:RL-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bram_en) begin
            for (int i = 0; i < 4; i++)
                if (bram_we[i]) mem[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
        end
        if (bram_en) rd_pipe[0] <= mem[bram_addr];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bram_dout = rd_pipe[RL-1];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Reference model: byte array covering 0x100..0x13F
    logic [7:0] shadow [0:63];

    function automatic bit ref_legal(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return (addr % 2) == 0;
            2'd2:    return (addr % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_we(input logic [3:0] mask, input logic [31:0] addr);
        int off;
        logic [3:0] r;
        off = int'(addr % 4);
        r = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= off) begin
                if (mask[i-off]) r[i] = 1'b1;
            end
        return r;
    endfunction

    function automatic logic [31:0] ref_din(input logic [31:0] wdata, input logic [31:0] addr);
        int off;
        logic [31:0] r;
        off = int'(addr % 4);
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i >= off) r = r | (((wdata >> (8*(i-off))) & 32'hFF) << (8*i));
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] addr);
        int idx;
        int off;
        idx = int'(addr) - 32'h100;
        off = int'(addr % 4);
        for (int j = 0; j < 4; j++)
            if (mask[j] && (off + j) < 4 && idx >= 0 && (idx + j) < 64)
                shadow[idx+j] = 8'((wdata >> (8*j)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr);
        int idx;
        int off;
        logic [31:0] r;
        idx = int'(addr) - 32'h100;
        off = int'(addr % 4);
        r = 32'h0;
        for (int j = 0; j < 4; j++)
            if ((off + j) < 4) r = r | (32'(shadow[idx+j]) << (8*j));
        return r;
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input bit fl);
        pipe.req_read  = rd;
        pipe.req_write = wr;
        pipe.req_size  = size;
        pipe.req_addr  = addr;
        pipe.req_wdata = wdata;
        pipe.req_wmask = mask;
        pipe.flush     = fl;
    endtask

    task automatic idle_req();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a load at the current cycle and follow it to rdata_valid.
    task automatic run_load(input string nm, input logic [1:0] size, input logic [31:0] addr,
                            output logic [31:0] got);
        int stalls;
        int vcyc;
        logic [31:0] exp;
        stalls = 0;
        vcyc = -1;
        got = 32'h0;
        exp = ref_load(addr);
        drive(1'b1, 1'b0, size, addr, 32'h0, 4'h0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk({nm, "_issue_en"}, 32'(bram_en), 32'd1);
                chk({nm, "_issue_addr"}, 32'(bram_addr), (addr >> 2) & 32'hFFF);
            end
            if (pipe.stall) stalls++;
            if (pipe.rdata_valid) begin
                vcyc = c;
                got = pipe.rdata;
                chk({nm, "_rdata"}, pipe.rdata, exp);
            end
            step();
            if (vcyc >= 0) break;
        end
        idle_req();
        chk({nm, "_valid_cycle"}, 32'(vcyc), 32'(RL + 1));
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(RL + 1));
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        bit          fl;
        bit          e_en;
        logic [3:0]  e_we;
        logic [31:0] e_din;
        bit          e_mis;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  mk;
        logic [1:0]  sz;
        bit          rd;
        bit          wr;
        bit          fl;
        bit          seen;
        bit          exp_en;
        int          r;

        //            rd    wr    size    addr      wdata         mask  fl    en    we     din           mis
        tbl[0]  = '{1'b0, 1'b1, SIZE_W, 32'h104, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, SIZE_B, 32'h103, 32'h000000A5, 4'h1, 1'b0, 1'b1, 4'h8, 32'hA5000000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, SIZE_H, 32'h10A, 32'h0000BEEF, 4'h3, 1'b0, 1'b1, 4'hC, 32'hBEEF0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, SIZE_B, 32'h109, 32'h0000005A, 4'h1, 1'b0, 1'b1, 4'h2, 32'h00005A00, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, SIZE_W, 32'h106, 32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 1'b0, SIZE_H, 32'h101, 32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'b11,  32'h200, 32'h12345678, 4'hF, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 1'b1, SIZE_W, 32'h10C, 32'h11111111, 4'hF, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, SIZE_W, 32'h106, 32'h0,        4'h0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b1, SIZE_W, 32'h108, 32'h11223344, 4'hF, 1'b0, 1'b1, 4'hF, 32'h11223344, 1'b0};
        tbl[10] = '{1'b0, 1'b0, SIZE_W, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 1'b0, SIZE_H, 32'h102, 32'h0,        4'h0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};

        // Reset with a store held on the inputs: nothing may reach the BRAM
        rstn = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = 32'h0;
        drive(1'b0, 1'b1, SIZE_W, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b0);
        #3;
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_stall", 32'(pipe.stall), 32'd0);
        chk("rst_rdata_valid", 32'(pipe.rdata_valid), 32'd0);
        chk("rst_rdata", pipe.rdata, 32'd0);
        chk("rst_misalign", 32'(pipe.misalign), 32'd0);

        for (int w = 0; w < 16; w++) begin
            step();
            pl_en = 1'b1;
            pl_addr = ADDR_W'(32'h40 + w);
            pl_data = 32'h0;
        end
        step();
        pl_en = 1'b0;
        for (int b = 0; b < 64; b++) shadow[b] = 8'h00;
        idle_req();
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Single-cycle decode vectors
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), 32'(bram_en), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d_we", i), 32'(bram_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_misalign", i), 32'(pipe.misalign), 32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d_stall", i), 32'(pipe.stall), 32'd0);
            if (tbl[i].e_en) begin
                chk($sformatf("tbl%0d_din", i), bram_din, tbl[i].e_din);
                chk($sformatf("tbl%0d_addr", i), 32'(bram_addr), (tbl[i].addr >> 2) & 32'hFFF);
            end
            if (tbl[i].wr && !tbl[i].fl && ref_legal(tbl[i].size, tbl[i].addr))
                ref_store(tbl[i].wdata, tbl[i].mask, tbl[i].addr);
            step();
        end
        idle_req();

        // Byte stored at 0x103 reads back in lane 3
        run_load("lw_after_sb", SIZE_W, 32'h100, got);
        chk("lw_after_sb_byte3", 32'(got[31:24]), 32'hA5);

        // Halfword load from upper half with 2-cycle BRAM
        step();
        pl_en = 1'b1;
        pl_addr = ADDR_W'(32'h40);
        pl_data = 32'h1234ABCD;
        step();
        pl_en = 1'b0;
        shadow[0] = 8'hCD;
        shadow[1] = 8'hAB;
        shadow[2] = 8'h34;
        shadow[3] = 8'h12;
        run_load("lh_102", SIZE_H, 32'h102, got);
        chk("lh_102_low16", 32'(got[15:0]), 32'h1234);

        // Flush in the first WAIT cycle drops the load
        drive(1'b1, 1'b0, SIZE_W, 32'h104, 32'h0, 4'h0, 1'b0);
        step();
        pipe.flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_stall", 32'(pipe.stall), 32'd0);
        step();
        idle_req();
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pipe.rdata_valid || pipe.stall) seen = 1'b1;
            step();
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        drive(1'b0, 1'b1, SIZE_W, 32'h110, 32'hCAFEF00D, 4'hF, 1'b0);
        @(negedge clk);
        chk("post_flush_sw_en", 32'(bram_en), 32'd1);
        chk("post_flush_sw_we", 32'(bram_we), 32'hF);
        ref_store(32'hCAFEF00D, 4'hF, 32'h110);
        step();
        idle_req();
        run_load("post_flush_lw", SIZE_W, 32'h110, got);

        // Reset asserted mid-load, request still held
        drive(1'b1, 1'b0, SIZE_W, 32'h108, 32'h0, 4'h0, 1'b0);
        step();
        #1 rstn = 1'b0;
        #1;
        chk("midrst_stall", 32'(pipe.stall), 32'd0);
        chk("midrst_bram_en", 32'(bram_en), 32'd0);
        chk("midrst_rdata_valid", 32'(pipe.rdata_valid), 32'd0);
        chk("midrst_rdata", pipe.rdata, 32'd0);
        @(negedge clk);
        idle_req();
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (pipe.rdata_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        step();

        // Back-to-back loads: second issues the cycle after DONE
        run_load("b2b_first", SIZE_W, 32'h100, got);
        run_load("b2b_second", SIZE_W, 32'h108, got);

        // Random traffic against the byte model
        for (int n = 0; n < 300; n++) begin
            a  = 32'h100 + $urandom_range(0, 63);
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? SIZE_B : (r < 6) ? SIZE_H : (r < 9) ? SIZE_W : 2'b11;
            mk = (sz == SIZE_B) ? 4'h1 : (sz == SIZE_H) ? 4'h3 : (sz == SIZE_W) ? 4'hF : 4'($urandom_range(0, 15));
            wd = $urandom;
            r  = int'($urandom_range(0, 4));
            rd = (r <= 1) || (r == 4);
            wr = (r >= 2);
            fl = ($urandom_range(0, 7) == 0);
            if (rd && !wr && !fl && ref_legal(sz, a)) begin
                run_load($sformatf("rnd%0d_ld", n), sz, a, got);
            end else begin
                drive(rd, wr, sz, a, wd, mk, fl);
                exp_en = wr && !fl && ref_legal(sz, a);
                @(negedge clk);
                chk($sformatf("rnd%0d_en", n), 32'(bram_en), 32'(exp_en));
                chk($sformatf("rnd%0d_we", n), 32'(bram_we), exp_en ? 32'(ref_we(mk, a)) : 32'd0);
                chk($sformatf("rnd%0d_mis", n), 32'(pipe.misalign), 32'(!fl && !ref_legal(sz, a)));
                chk($sformatf("rnd%0d_stall", n), 32'(pipe.stall), 32'd0);
                if (exp_en) begin
                    chk($sformatf("rnd%0d_din", n), bram_din & {{8{bram_we[3]}}, {8{bram_we[2]}}, {8{bram_we[1]}}, {8{bram_we[0]}}},
                        ref_din(wd, a) & {{8{ref_we(mk, a) >= 4'h8}}, {8{ref_we(mk, a)[2]}}, {8{ref_we(mk, a)[1]}}, {8{ref_we(mk, a)[0]}}});
                    ref_store(wd, mk, a);
                end
                step();
                idle_req();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
